mem_port_adapter: RTL and testbench
===================================

Name: mem_port_adapter

Overview:
- Sits directly downstream of the multicycle control FSM and datapath, between the CPU memory port and the physical memory port.
- Latches each CPU request (mem_read/mem_write held until mem_resp), word-aligns the address, and shifts write byte-enables and data into the correct byte lanes.
- Runs the pmem handshake, registers the read word, and returns mem_resp as a single-cycle pulse.
- Read data is returned as the raw aligned word; lane extraction and sign extension for lb/lh/lbu/lhu stay in the datapath regfilemux.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ before abort. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- mem_address  in  32  CPU byte address
- mem_read  in  1  CPU read request, level, held until mem_resp
- mem_write  in  1  CPU write request, level, held until mem_resp
- mem_byte_enable  in  4  CPU byte mask, lane 0 aligned (0001 = sb, 0011 = sh, 1111 = sw)
- mem_wdata  in  32  CPU store data, lane 0 aligned
- mem_rdata  out  32  registered raw read word
- mem_resp  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle pulse: shifted mask spilled past byte 3
- pmem_address  out  32  {addr[31:2], 2'b00}
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_wmask  out  4  lane-shifted byte mask
- pmem_wdata  out  32  lane-shifted write data
- pmem_rdata  in  32  physical read word
- pmem_resp  in  1  physical completion, valid one cycle

Behaviour:
- Reset: state=IDLE; every output register = 0 (mem_rdata, mem_resp, misalign, all pmem_* outputs). A reset mid-REQ drops the pmem strobes the next cycle; the transaction is abandoned.
- IDLE:
  - On mem_read|mem_write, capture the aligned address, op, shifted mask/data and the misalign flag, then go to REQ.
  - If both are asserted, treat the request as a write and pulse misalign.
  - Ignore pmem_resp in IDLE.
- Lane shift:
  - off = addr[1:0]
  - pmem_wmask = (mem_byte_enable << off)[3:0]
  - pmem_wdata = mem_wdata << (8*off)
  - misalign = |(({4'b0, mem_byte_enable} << off)[7:4]); pulses in the cycle after capture.
- REQ:
  - pmem_read or pmem_write is held at 1 with stable captured address, mask and data.
  - On pmem_resp: latch pmem_rdata into mem_rdata (reads only; writes leave it unchanged) and go to RESP.
- RESP:
  - mem_resp = 1 for exactly this cycle; pmem strobes = 0; next state is IDLE.
  - The cycle after RESP is IDLE. A still-asserted request there starts a new transaction; the control FSM has already left its wait state, so this does not occur in normal use.
- CPU inputs changing during REQ/RESP are ignored. A transaction always completes on the captured values.
- Latency: request at cycle t → strobe from t+1; pmem_resp at cycle u → mem_resp at u+1. Minimum is 2 cycles from request to mem_resp.

Optional Feature:
- Macro MEM_PORT_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle.
  - At TIMEOUT_CYCLES without pmem_resp: drop strobes, set mem_rdata=32'h0, go to RESP (mem_resp pulse), and set sticky output timeout_err (1 bit) until rst.
- Undefined: no counter and no timeout_err port; REQ waits indefinitely.

Decomposition:
- rv32i_types package: rv32i_word and rv32i_mem_wmask (existing); add mem_port_state_t enum {IDLE, REQ, RESP}.
- Sub-module mem_lane_align: combinational shift of mask and data plus misalign detection; instantiated once.

Test Plan:
- sw addr 0x100, wdata 0xA5A5A5A5, pmem_resp after 3 cycles → pmem_address 0x100, wmask 1111, mem_resp exactly 1 cycle at resp+1.
- sb addr 0x203, byte_enable 0001, wdata 0x000000EE → pmem_address 0x200, wmask 1000, wdata 0xEE000000, misalign 0.
- sh addr 0x203, byte_enable 0011 → wmask 1000, misalign pulses 1.
- read addr 0x40, pmem_rdata 0xCAFEF00D with resp in the same cycle as the strobe → mem_rdata 0xCAFEF00D, mem_resp 2 cycles after request.
- rst asserted mid-REQ, then pmem_resp arrives → strobes 0 next cycle, no mem_resp, state IDLE.
- With MEM_PORT_TIMEOUT_EN, TIMEOUT_CYCLES=4, no pmem_resp → mem_resp after 4 REQ cycles, mem_rdata 0, timeout_err stays 1.

Source files
------------

// File: rtl/mem_port_adapter_pkg.sv
// Shared types for the CPU-to-physical memory port adapter.
package mem_port_adapter_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_port_state_t;

endpackage

// File: rtl/mem_port_adapter_if.sv
// Word-wide memory bus. On the CPU side wmask is the lane-0 aligned byte enable;
// on the physical side it is the lane-shifted write mask.
interface mem_port_adapter_if;
  import mem_port_adapter_pkg::*;

  rv32i_word      address;
  logic           read;
  logic           write;
  rv32i_mem_wmask wmask;
  rv32i_word      wdata;
  rv32i_word      rdata;
  logic           resp;

  modport master (
    output address, read, write, wmask, wdata,
    input  rdata, resp
  );

  modport slave (
    input  address, read, write, wmask, wdata,
    output rdata, resp
  );

endinterface

// File: rtl/mem_lane_align.sv
// Moves a lane-0 aligned byte mask and store word into the byte lanes selected by the
// low address bits, and flags masks that spill past byte 3.
module mem_lane_align
  import mem_port_adapter_pkg::*;
(
  input  logic [1:0]     offset,
  input  rv32i_mem_wmask byte_enable,
  input  rv32i_word      wdata,
  output rv32i_mem_wmask wmask,
  output rv32i_word      wdata_shifted,
  output logic           spill
);

  logic [7:0] mask_wide;

  always_comb begin
    mask_wide     = {4'b0000, byte_enable} << offset;
    wmask         = mask_wide[3:0];
    spill         = |mask_wide[7:4];
    wdata_shifted = wdata << {offset, 3'b000};
  end

endmodule

// File: rtl/mem_port_adapter.sv
// Bridges the CPU memory port to the physical memory port: latches a request, aligns it,
// runs the pmem handshake and returns a one-cycle mem_resp. Define MEM_PORT_TIMEOUT_EN
// to abort stalled requests after TIMEOUT_CYCLES and raise a sticky timeout_err.
module mem_port_adapter
  import mem_port_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  rv32i_word      mem_address,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_mem_wmask mem_byte_enable,
  input  rv32i_word      mem_wdata,
  output rv32i_word      mem_rdata,
  output logic           mem_resp,
  output logic           misalign,
  output rv32i_word      pmem_address,
  output logic           pmem_read,
  output logic           pmem_write,
  output rv32i_mem_wmask pmem_wmask,
  output rv32i_word      pmem_wdata,
  input  rv32i_word      pmem_rdata,
  input  logic           pmem_resp
`ifdef MEM_PORT_TIMEOUT_EN
  ,
  output logic           timeout_err
`endif
);

  mem_port_state_t state_q;
  rv32i_word       addr_q, wdata_q, rdata_q;
  rv32i_mem_wmask  wmask_q;
  logic            rd_q, wr_q, resp_q, misalign_q;

  rv32i_mem_wmask  lane_wmask;
  rv32i_word       lane_wdata;
  logic            lane_spill;

  mem_lane_align u_lane_align (
    .offset        (mem_address[1:0]),
    .byte_enable   (mem_byte_enable),
    .wdata         (mem_wdata),
    .wmask         (lane_wmask),
    .wdata_shifted (lane_wdata),
    .spill         (lane_spill)
  );

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            expired;
  // cnt_q counts REQ cycles already spent, so this is the last permitted one
  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      resp_q     <= 1'b0;
      misalign_q <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      resp_q     <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q     <= {mem_address[31:2], 2'b00};
            wmask_q    <= lane_wmask;
            wdata_q    <= lane_wdata;
            // Simultaneous read and write resolves to a write and is reported
            rd_q       <= !mem_write;
            wr_q       <= mem_write;
            misalign_q <= lane_spill || (mem_read && mem_write);
`ifdef MEM_PORT_TIMEOUT_EN
            cnt_q      <= '0;
`endif
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (pmem_resp) begin
            if (rd_q) rdata_q <= pmem_rdata;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= RESP;
          end
`ifdef MEM_PORT_TIMEOUT_EN
          else if (expired) begin
            rdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            resp_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_address = addr_q;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_wmask   = wmask_q;
  assign pmem_wdata   = wdata_q;
  assign mem_rdata    = rdata_q;
  assign mem_resp     = resp_q;
  assign misalign     = misalign_q;
`ifdef MEM_PORT_TIMEOUT_EN
  assign timeout_err  = timeout_q;
`endif

endmodule

// File: tb/tb_mem_port_adapter.sv
// Self-checking bench for mem_port_adapter: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_port_adapter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic misalign;
`ifdef MEM_PORT_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_port_adapter_if cpu_bus ();
  mem_port_adapter_if pmem_bus ();

  mem_port_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (cpu_bus.address),
    .mem_read        (cpu_bus.read),
    .mem_write       (cpu_bus.write),
    .mem_byte_enable (cpu_bus.wmask),
    .mem_wdata       (cpu_bus.wdata),
    .mem_rdata       (cpu_bus.rdata),
    .mem_resp        (cpu_bus.resp),
    .misalign        (misalign),
    .pmem_address    (pmem_bus.address),
    .pmem_read       (pmem_bus.read),
    .pmem_write      (pmem_bus.write),
    .pmem_wmask      (pmem_bus.wmask),
    .pmem_wdata      (pmem_bus.wdata),
    .pmem_rdata      (pmem_bus.rdata),
    .pmem_resp       (pmem_bus.resp)
`ifdef MEM_PORT_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one request in flight, answered by one response cycle.
  bit          chk_en = 0;
  bit          m_busy, m_resp, m_mis, m_rd, m_wr, m_terr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_mask;
  int          m_wait, m_off, m_wide;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_mis = 0; m_rd = 0; m_wr = 0; m_terr = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_mask = 0; m_wait = 0;
    end else begin
      m_mis = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (m_busy) begin
        if (pmem_bus.resp) begin
          if (m_rd) m_rdata = pmem_bus.rdata;
          m_busy = 0;
          m_resp = 1;
        end else begin
          m_wait++;
`ifdef MEM_PORT_TIMEOUT_EN
          if (m_wait == TO) begin
            m_rdata = 0;
            m_terr  = 1;
            m_busy  = 0;
            m_resp  = 1;
          end
`endif
        end
      end else if (cpu_bus.read || cpu_bus.write) begin
        m_off   = int'(cpu_bus.address % 4);
        m_wide  = int'(cpu_bus.wmask) * (2 ** m_off);
        m_addr  = cpu_bus.address - 32'(m_off);
        m_mask  = 4'(m_wide % 16);
        m_wdata = 32'(64'(cpu_bus.wdata) * (64'd1 << (8 * m_off)));
        m_mis   = (m_wide > 15) || (cpu_bus.read && cpu_bus.write);
        m_wr    = cpu_bus.write;
        m_rd    = !cpu_bus.write;
        m_busy  = 1;
        m_wait  = 0;
      end
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_rdata",    cpu_bus.rdata,    m_rdata);
      check("mem_resp",     32'(cpu_bus.resp), 32'(m_resp));
      check("misalign",     32'(misalign),     32'(m_mis));
      check("pmem_address", pmem_bus.address, m_addr);
      check("pmem_read",    32'(pmem_bus.read),  32'(m_busy && m_rd));
      check("pmem_write",   32'(pmem_bus.write), 32'(m_busy && m_wr));
      check("pmem_wmask",   32'(pmem_bus.wmask), 32'(m_mask));
      check("pmem_wdata",   pmem_bus.wdata,   m_wdata);
`ifdef MEM_PORT_TIMEOUT_EN
      check("timeout_err",  32'(timeout_err),  32'(m_terr));
`endif
    end
  end

  // dly = REQ cycle in which pmem_resp is given (0 = never); returns latency and snapshots.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int dly, input logic [31:0] rdat,
                        output int lat, output int width, output bit mis,
                        output logic [31:0] c_addr, output logic [3:0] c_mask,
                        output logic [31:0] c_data, output bit c_rd, output bit c_wr);
    cpu_bus.read = rd; cpu_bus.write = wr; cpu_bus.address = a;
    cpu_bus.wmask = be; cpu_bus.wdata = wd;
    width = 0;
    cyc();
    lat = 1;
    mis = misalign; c_addr = pmem_bus.address; c_mask = pmem_bus.wmask;
    c_data = pmem_bus.wdata; c_rd = pmem_bus.read; c_wr = pmem_bus.write;
    if (dly > 0) begin
      for (int i = 1; i < dly; i++) begin cyc(); lat++; end
      pmem_bus.resp = 1'b1; pmem_bus.rdata = rdat;
      cyc(); lat++;
      pmem_bus.resp = 1'b0;
    end
    while (!cpu_bus.resp && lat < 40) begin cyc(); lat++; end
    cpu_bus.read = 1'b0; cpu_bus.write = 1'b0;
    while (cpu_bus.resp && width < 8) begin width++; cyc(); end
  endtask

  int          lat, width, n, gap, kind;
  bit          mis, c_rd, c_wr;
  logic [31:0] c_addr, c_data;
  logic [3:0]  c_mask;

  initial begin
    cpu_bus.read = 0; cpu_bus.write = 0; cpu_bus.address = 0; cpu_bus.wmask = 0;
    cpu_bus.wdata = 0; pmem_bus.resp = 0; pmem_bus.rdata = 0;
    repeat (2) cyc();
    check("rst_mem_resp",   32'(cpu_bus.resp), 0);
    check("rst_pmem_read",  32'(pmem_bus.read), 0);
    check("rst_pmem_write", 32'(pmem_bus.write), 0);
    check("rst_pmem_addr",  pmem_bus.address, 0);
    check("rst_mem_rdata",  cpu_bus.rdata, 0);
    rst = 0;

    do_txn(0, 1, 32'h100, 4'hF, 32'hA5A5A5A5, 3, 32'h0, lat, width, mis, c_addr, c_mask, c_data,
           c_rd, c_wr);
    check("sw_addr", c_addr, 32'h100);
    check("sw_mask", 32'(c_mask), 32'hF);
    check("sw_data", c_data, 32'hA5A5A5A5);
    check("sw_strobe", 32'(c_wr), 1);
    check("sw_latency", 32'(lat), 4);
    check("sw_resp_width", 32'(width), 1);
    check("sw_misalign", 32'(mis), 0);

    do_txn(0, 1, 32'h203, 4'h1, 32'h000000EE, 1, 32'h0, lat, width, mis, c_addr, c_mask, c_data,
           c_rd, c_wr);
    check("sb_addr", c_addr, 32'h200);
    check("sb_mask", 32'(c_mask), 32'h8);
    check("sb_data", c_data, 32'hEE000000);
    check("sb_misalign", 32'(mis), 0);

    do_txn(0, 1, 32'h203, 4'h3, 32'h0000BEEF, 2, 32'h0, lat, width, mis, c_addr, c_mask, c_data,
           c_rd, c_wr);
    check("sh_mask", 32'(c_mask), 32'h8);
    check("sh_data", c_data, 32'hEF000000);
    check("sh_misalign", 32'(mis), 1);

    do_txn(1, 0, 32'h40, 4'hF, 32'h0, 1, 32'hCAFEF00D, lat, width, mis, c_addr, c_mask, c_data,
           c_rd, c_wr);
    check("rd_strobe", 32'(c_rd), 1);
    check("rd_latency", 32'(lat), 2);
    check("rd_resp_width", 32'(width), 1);
    check("rd_data", cpu_bus.rdata, 32'hCAFEF00D);

    do_txn(1, 1, 32'h44, 4'hF, 32'h12345678, 1, 32'h55555555, lat, width, mis, c_addr, c_mask,
           c_data, c_rd, c_wr);
    check("both_write", 32'(c_wr), 1);
    check("both_no_read", 32'(c_rd), 0);
    check("both_misalign", 32'(mis), 1);
    check("wr_keeps_rdata", cpu_bus.rdata, 32'hCAFEF00D);

    // Reset while the physical read is outstanding
    cpu_bus.read = 1; cpu_bus.address = 32'h80;
    cyc();
    check("mid_rst_strobe_on", 32'(pmem_bus.read), 1);
    rst = 1; cpu_bus.read = 0;
    cyc();
    check("mid_rst_strobe_off", 32'(pmem_bus.read), 0);
    rst = 0; pmem_bus.resp = 1; pmem_bus.rdata = 32'hDEADBEEF;
    cyc();
    pmem_bus.resp = 0;
    check("mid_rst_no_resp0", 32'(cpu_bus.resp), 0);
    cyc();
    check("mid_rst_no_resp1", 32'(cpu_bus.resp), 0);
    check("mid_rst_rdata", cpu_bus.rdata, 0);

`ifdef MEM_PORT_TIMEOUT_EN
    do_txn(1, 0, 32'h300, 4'hF, 32'h0, 0, 32'h0, lat, width, mis, c_addr, c_mask, c_data,
           c_rd, c_wr);
    check("to_latency", 32'(lat), 32'(TO + 1));
    check("to_rdata", cpu_bus.rdata, 0);
    repeat (3) cyc();
    check("to_sticky", 32'(timeout_err), 1);
`endif

    repeat (300) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        pmem_bus.resp = ($urandom_range(0, 2) == 0);
        pmem_bus.rdata = $urandom;
        cyc();
      end
      kind = $urandom_range(0, 5);
      cpu_bus.read  = (kind <= 2) || (kind == 5);
      cpu_bus.write = (kind >= 3);
      cpu_bus.address = $urandom;
      cpu_bus.wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       cpu_bus.wmask = 4'h1;
        1:       cpu_bus.wmask = 4'h3;
        2:       cpu_bus.wmask = 4'hF;
        default: cpu_bus.wmask = 4'($urandom_range(0, 15));
      endcase
      n = 0;
      do begin
        pmem_bus.resp = ($urandom_range(0, 2) == 0);
        pmem_bus.rdata = $urandom;
        cyc();
        n++;
        if (n > 1) begin
          cpu_bus.address = $urandom;
          cpu_bus.wdata = $urandom;
          cpu_bus.wmask = 4'($urandom_range(0, 15));
        end
      end while (!cpu_bus.resp && n < 64);
      check("rand_resp_seen", 32'(cpu_bus.resp), 1);
      cpu_bus.read = 0; cpu_bus.write = 0;
    end
    pmem_bus.resp = 0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
